// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet AXI-Lite register block: register map,
// CTRL bit positions, identification default and AXI response codes.
package eth_pkg;

  // Byte offsets of the register map; only bits [4:2] are decoded.
  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_ID      = 5'h04;
  localparam logic [4:0] OFF_RX_CNT  = 5'h08;
  localparam logic [4:0] OFF_TX_CNT  = 5'h0C;
  localparam logic [4:0] OFF_CRC_CNT = 5'h10;
  localparam logic [4:0] OFF_SCRATCH = 5'h14;

  localparam logic [2:0] IDX_CTRL    = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_ID      = OFF_ID[4:2];
  localparam logic [2:0] IDX_RX_CNT  = OFF_RX_CNT[4:2];
  localparam logic [2:0] IDX_TX_CNT  = OFF_TX_CNT[4:2];
  localparam logic [2:0] IDX_CRC_CNT = OFF_CRC_CNT[4:2];
  localparam logic [2:0] IDX_SCRATCH = OFF_SCRATCH[4:2];

  localparam int CTRL_TX_TEST_EN_BIT = 0;
  localparam int CTRL_SOFT_RST_BIT   = 1;

  localparam logic [31:0] ID_DEFAULT = 32'h0E7A_0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } wbeat_t;

  function automatic logic idx_mapped(input logic [2:0] idx);
    return idx <= IDX_SCRATCH;
  endfunction

endpackage

// File: rtl/eth_sat_cnt.sv
// Saturating event counter: +1 per pulse, sticks at all-ones, synchronous clear.
module eth_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         pulse_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A clear that lands on the same edge as a pulse still counts that pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = pulse_i ? {{(W-1){1'b0}}, 1'b1} : '0;
    end else if (pulse_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/eth_axil_regs.sv
// AXI4-Lite slave holding Ethernet MAC control, ID, frame/CRC counters and scratch.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
module eth_axil_regs
  import eth_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic        AXI_Clk,
  input  logic        AXI_Rstn,
  input  logic        AXI_awvalid,
  output logic        AXI_awready,
  input  logic [31:0] AXI_awaddr,
  input  logic        AXI_wvalid,
  output logic        AXI_wready,
  input  logic [31:0] AXI_wdata,
  input  logic [3:0]  AXI_wstrb,
  output logic        AXI_bvalid,
  input  logic        AXI_bready,
  output logic [1:0]  AXI_bresp,
  input  logic        AXI_arvalid,
  output logic        AXI_arready,
  input  logic [31:0] AXI_araddr,
  output logic        AXI_rvalid,
  input  logic        AXI_rready,
  output logic [31:0] AXI_rdata,
  output logic [1:0]  AXI_rresp,
  input  logic        Rx_Frame_Pulse,
  input  logic        Tx_Frame_Pulse,
  input  logic        Rx_Crc_Err_Pulse,
  output logic        Ctrl_Tx_Test_En,
  output logic        Ctrl_Soft_Rst,
  output logic        Dbg_Rd_State
);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  logic        ready_en_q;
  logic        aw_held_q, aw_held_d;
  logic [2:0]  aw_idx_q, aw_idx_d;
  logic        w_held_q, w_held_d;
  wbeat_t      wbeat_q, wbeat_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        tx_en_q, tx_en_d;
  logic        soft_rst_q, soft_rst_d;
  logic [31:0] scratch_q, scratch_d;
  logic [0:0]  r_state_q, r_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic        aw_hs, w_hs, b_hs, ar_hs, commit;
  logic [2:0]  c_idx;
  wbeat_t      c_beat;
  logic        clr_rx, clr_tx, clr_crc;
  logic [31:0] rx_cnt, tx_cnt, crc_cnt;
  logic [31:0] rd_mux_data;
  logic [1:0]  rd_mux_resp;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{AXI_awaddr[31:5], AXI_awaddr[1:0],
                              AXI_araddr[31:5], AXI_araddr[1:0]};

  // ready_en_q keeps all ready outputs low while reset is asserted.
  assign AXI_awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign AXI_wready  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign AXI_arready = ready_en_q & (r_state_q == R_IDLE);

  assign aw_hs = AXI_awvalid & AXI_awready;
  assign w_hs  = AXI_wvalid & AXI_wready;
  assign b_hs  = bvalid_q & AXI_bready;
  assign ar_hs = AXI_arvalid & AXI_arready;

  assign c_idx  = aw_held_q ? aw_idx_q : AXI_awaddr[4:2];
  assign c_beat = w_held_q ? wbeat_q : '{data: AXI_wdata, strb: AXI_wstrb};
  assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

  assign clr_rx  = commit & (c_idx == IDX_RX_CNT);
  assign clr_tx  = commit & (c_idx == IDX_TX_CNT);
  assign clr_crc = commit & (c_idx == IDX_CRC_CNT);

  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wbeat_d    = wbeat_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    tx_en_d    = tx_en_q;
    scratch_d  = scratch_q;
    soft_rst_d = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = AXI_awaddr[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wbeat_d  = '{data: AXI_wdata, strb: AXI_wstrb};
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = idx_mapped(c_idx) ? RESP_OKAY : RESP_SLVERR;
      if (c_idx == IDX_CTRL && c_beat.strb[0]) begin
        tx_en_d    = c_beat.data[CTRL_TX_TEST_EN_BIT];
        soft_rst_d = c_beat.data[CTRL_SOFT_RST_BIT];
      end
      if (c_idx == IDX_SCRATCH) begin
        for (int b = 0; b < 4; b++) begin
          if (c_beat.strb[b]) scratch_d[8*b +: 8] = c_beat.data[8*b +: 8];
        end
      end
    end
    // Both held beats stay parked until the response is accepted.
    if (b_hs) begin
      bvalid_d  = 1'b0;
      bresp_d   = RESP_OKAY;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_comb begin
    rd_mux_data = '0;
    rd_mux_resp = RESP_OKAY;
    case (AXI_araddr[4:2])
      IDX_CTRL:    rd_mux_data[CTRL_TX_TEST_EN_BIT] = tx_en_q;
      IDX_ID:      rd_mux_data = ID_VALUE;
      IDX_RX_CNT:  rd_mux_data = rx_cnt;
      IDX_TX_CNT:  rd_mux_data = tx_cnt;
      IDX_CRC_CNT: rd_mux_data = crc_cnt;
      IDX_SCRATCH: rd_mux_data = scratch_q;
      default:     rd_mux_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (r_state_q == R_IDLE) begin
      if (ar_hs) begin
        r_state_d = R_RESP;
        rdata_d   = rd_mux_data;
        rresp_d   = rd_mux_resp;
      end
    end else if (AXI_rready) begin
      r_state_d = R_IDLE;
    end
  end

  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wbeat_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      tx_en_q    <= 1'b0;
      soft_rst_q <= 1'b0;
      scratch_q  <= '0;
      r_state_q  <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wbeat_q    <= wbeat_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      tx_en_q    <= tx_en_d;
      soft_rst_q <= soft_rst_d;
      scratch_q  <= scratch_d;
      r_state_q  <= r_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  eth_sat_cnt #(.W(32)) u_rx_cnt (
    .clk_i(AXI_Clk), .rst_ni(AXI_Rstn), .pulse_i(Rx_Frame_Pulse), .clr_i(clr_rx), .count_o(rx_cnt)
  );
  eth_sat_cnt #(.W(32)) u_tx_cnt (
    .clk_i(AXI_Clk), .rst_ni(AXI_Rstn), .pulse_i(Tx_Frame_Pulse), .clr_i(clr_tx), .count_o(tx_cnt)
  );
  eth_sat_cnt #(.W(32)) u_crc_cnt (
    .clk_i(AXI_Clk), .rst_ni(AXI_Rstn), .pulse_i(Rx_Crc_Err_Pulse), .clr_i(clr_crc), .count_o(crc_cnt)
  );

  assign AXI_bvalid      = bvalid_q;
  assign AXI_bresp       = bresp_q;
  assign AXI_rvalid      = (r_state_q == R_RESP);
  assign AXI_rdata       = rdata_q;
  assign AXI_rresp       = rresp_q;
  assign Ctrl_Tx_Test_En = tx_en_q;
  assign Ctrl_Soft_Rst   = soft_rst_q;
  assign Dbg_Rd_State    = r_state_q;

endmodule

// File: doc/eth_axil_regs.md
ETH_AXIL_REGS -- requirements
Module: eth_axil_regs

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h0E7A_0001, constant returned at ID register.
REQ-002 SHALL have port AXI_Clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port AXI_Rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports AXI_awvalid in 1, AXI_awready out 1, AXI_awaddr in 32: write address channel.
REQ-005 SHALL have ports AXI_wvalid in 1, AXI_wready out 1, AXI_wdata in 32, AXI_wstrb in 4: write data channel.
REQ-006 SHALL have ports AXI_bvalid out 1, AXI_bready in 1, AXI_bresp out 2: write response channel.
REQ-007 SHALL have ports AXI_arvalid in 1, AXI_arready out 1, AXI_araddr in 32: read address channel.
REQ-008 SHALL have ports AXI_rvalid out 1, AXI_rready in 1, AXI_rdata out 32, AXI_rresp out 2: read data channel.
REQ-009 SHALL have port Rx_Frame_Pulse  input  1  one-cycle pulse per received frame, AXI_Clk domain.
REQ-010 SHALL have port Tx_Frame_Pulse  input  1  one-cycle pulse per transmitted frame, AXI_Clk domain.
REQ-011 SHALL have port Rx_Crc_Err_Pulse  input  1  one-cycle pulse per CRC-failed frame, AXI_Clk domain.
REQ-012 SHALL have port Ctrl_Tx_Test_En  output  1  level from CTRL[0].
REQ-013 SHALL have port Ctrl_Soft_Rst  output  1  one-cycle pulse on write of 1 to CTRL[1].

Function
REQ-014 SHALL decode AXI_*addr[4:2] only; upper bits and [1:0] ignored.
REQ-015 SHALL map: 0x00 CTRL RW ([0] tx_test_en, [1] soft_rst self-clearing, reads 0), 0x04 ID RO, 0x08 RX_CNT, 0x0C TX_CNT, 0x10 CRC_CNT, 0x14 SCRATCH RW 32-bit.
REQ-016 SHALL treat counters as 32-bit, +1 per input pulse, saturating at 0xFFFF_FFFF, cleared by any write to their address (data ignored).
REQ-017 SHALL, when clear and pulse coincide on a counter, load 1.
REQ-018 SHALL apply AXI_wstrb per byte to CTRL and SCRATCH; strobe 0 leaves byte unchanged.
REQ-019 SHALL accept AW and W independently: awready=1 while no address held and bvalid=0; wready=1 while no data held and bvalid=0; each channel holds at most one beat.
REQ-020 SHALL commit the write on the edge where both address and data are held (or both handshake same cycle), asserting bvalid on that same edge.
REQ-021 SHALL hold bvalid and bresp stable until bready; release both held beats on the B handshake.
REQ-022 SHALL return bresp OKAY (00) for mapped addresses including RO (write ignored, except counter clear) and SLVERR (10) for offsets 0x18-0x1C, no state change.
REQ-023 SHALL run read FSM R_IDLE -> R_RESP: arready=1 only in R_IDLE; on AR handshake capture rdata/rresp and assert rvalid next edge; return to R_IDLE on R handshake.
REQ-024 SHALL hold rdata/rresp stable while rvalid=1 and rready=0; counters keep counting underneath.
REQ-025 SHALL return rdata 0 with rresp SLVERR for unmapped offsets.
REQ-026 SHALL process read and write channels concurrently; a same-cycle read of a register being written returns the pre-write value.
REQ-027 SHALL pulse Ctrl_Soft_Rst the cycle after the committing edge; it SHALL NOT reset this block's registers.

Reset
REQ-028 SHALL, on AXI_Rstn=0, asynchronously clear all registers, counters, held beats; awready, wready, bvalid, arready, rvalid, Ctrl_* = 0, bresp/rresp = 00, rdata = 0.
REQ-029 SHALL assert awready, wready, arready the first edge after AXI_Rstn deasserts.
REQ-030 SHALL abandon any in-flight transaction on reset mid-operation; no response issued afterwards.

Structure
REQ-031 SHALL place register offsets, CTRL bit indices, ID default, and resp codes (OKAY, SLVERR) in shared package eth_pkg.
REQ-032 SHALL implement counters as three instances of sub-module eth_sat_cnt (pulse, clear, 32-bit saturating value).

Verification
REQ-033 Write 0x0000_0001 to 0x00, strb 0xF -> bresp 00, Ctrl_Tx_Test_En=1; read 0x00 -> 0x0000_0001.
REQ-034 W beat 2 cycles before AW, data 0xA5A5_5A5A strb 0x3 to 0x14 (prior 0) -> bvalid with AW handshake; read -> 0x0000_5A5A.
REQ-035 5 Rx_Frame_Pulse, read 0x08 -> 5; write 0x08 coinciding with a pulse -> read 1.
REQ-036 Read 0x18 -> rresp 10, rdata 0; write 0x1C -> bresp 10; SCRATCH unchanged.
REQ-037 Hold rready=0 for 10 cycles during RX_CNT read with pulses -> rdata constant; next read shows increased count.
REQ-038 Drop AXI_Rstn while bvalid=1 awaiting bready -> bvalid=0 immediately; CTRL=0 after release.
